// File: rtl/spi_fpga_master_slave.sv
// SPI master and SPI slave sharing one system clock; the slave oversamples its
// SPI inputs on IN_CLOCK rather than using SCLK as a clock.
module spi_fpga_master_slave #(
    parameter int unsigned BIT_PER_SECOND                    = 12500000,
    parameter int unsigned CLOCK_FREQUENCY                   = 50000000,
    parameter int unsigned PACK_LENGTH                       = 8,
    parameter int unsigned CPOL                              = 0,
    parameter int unsigned CPHA                              = 1,
    parameter int unsigned MASTER_PACK_BIT_SEQUENCE_TRANSMIT = 1,
    parameter int unsigned MASTER_PACK_BIT_SEQUENCE_RECEIVE  = 0,
    parameter int unsigned SLAVE_PACK_BIT_SEQUENCE_TRANSMIT  = 0,
    parameter int unsigned SLAVE_PACK_BIT_SEQUENCE_RECEIVE   = 1
) (
    input  logic                   IN_CLOCK,
    input  logic                   IN_RESET_N,
    input  logic                   IN_LAUNCH,
    input  logic [PACK_LENGTH-1:0] IN_MASTER_DATA,
    input  logic                   IN_MISO,
    output logic                   OUT_MOSI,
    output logic                   OUT_CS,
    output logic                   OUT_SCLK,
    output logic [PACK_LENGTH-1:0] OUT_MASTER_RECEIVE_DATA,
    output logic                   OUT_MASTER_ACTION_DONE,
    input  logic [PACK_LENGTH-1:0] IN_SLAVE_TRANSMIT_DATA,
    input  logic                   IN_SLAVE_MOSI,
    input  logic                   IN_SLAVE_CS,
    input  logic                   IN_SLAVE_SCLK,
    input  logic                   IN_SLAVE_RESET,
    output logic                   OUT_SLAVE_MISO,
    output logic [PACK_LENGTH-1:0] OUT_SLAVE_RECEIVE_DATA
);

    localparam int unsigned HALF  = CLOCK_FREQUENCY / (2 * BIT_PER_SECOND);
    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned HP_W  = $clog2(2 * PACK_LENGTH);
    localparam int unsigned BC_W  = $clog2(PACK_LENGTH + 1) + 1;

    localparam logic IDLE_LVL = (CPOL != 0);
    localparam logic CPHA1    = (CPHA != 0);
    localparam logic M_TX_MSB = (MASTER_PACK_BIT_SEQUENCE_TRANSMIT != 0);
    localparam logic M_RX_MSB = (MASTER_PACK_BIT_SEQUENCE_RECEIVE != 0);
    localparam logic S_TX_MSB = (SLAVE_PACK_BIT_SEQUENCE_TRANSMIT != 0);
    localparam logic S_RX_MSB = (SLAVE_PACK_BIT_SEQUENCE_RECEIVE != 0);

    function automatic logic head(input logic [PACK_LENGTH-1:0] w, input logic msb_first);
        return msb_first ? w[PACK_LENGTH-1] : w[0];
    endfunction

    function automatic logic [PACK_LENGTH-1:0] advance(input logic [PACK_LENGTH-1:0] w,
                                                       input logic msb_first);
        return msb_first ? {w[PACK_LENGTH-2:0], 1'b0} : {1'b0, w[PACK_LENGTH-1:1]};
    endfunction

    // After PACK_LENGTH inserts the first bit sits in the MSB (first_to_msb) or bit 0.
    function automatic logic [PACK_LENGTH-1:0] insert(input logic [PACK_LENGTH-1:0] w,
                                                      input logic b,
                                                      input logic first_to_msb);
        return first_to_msb ? {w[PACK_LENGTH-2:0], b} : {b, w[PACK_LENGTH-1:1]};
    endfunction

    typedef enum logic [2:0] {
        M_IDLE,
        M_SETUP,
        M_SHIFT,
        M_HOLD,
        M_GAP
    } mstate_t;

    mstate_t                state, state_n;
    logic [CNT_W-1:0]       cnt;
    logic [HP_W-1:0]        hp;
    logic                   launch_q;
    logic [PACK_LENGTH-1:0] tx_sr, rx_sr, tx_adv;
    logic                   half_end, last_hp;
    logic                   start, lead, trail, first_lead, finish;

    assign half_end = (cnt == CNT_W'(HALF - 1));
    assign last_hp  = (hp == HP_W'(2 * PACK_LENGTH - 1));
    assign tx_adv   = advance(tx_sr, M_TX_MSB);

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) state <= M_IDLE;
        else             state <= state_n;
    end

    // The leading edge is issued as SETUP expires; later edges at each interior
    // half-period boundary, so the last half-period already sits at idle level.
    always_comb begin
        state_n    = state;
        start      = 1'b0;
        lead       = 1'b0;
        trail      = 1'b0;
        first_lead = 1'b0;
        finish     = 1'b0;
        case (state)
            M_IDLE: begin
                if (IN_LAUNCH && !launch_q) begin
                    start   = 1'b1;
                    state_n = M_SETUP;
                end
            end
            M_SETUP: begin
                if (half_end) begin
                    lead       = 1'b1;
                    first_lead = 1'b1;
                    state_n    = M_SHIFT;
                end
            end
            M_SHIFT: begin
                if (half_end) begin
                    if (last_hp) begin
                        state_n = M_HOLD;
                    end else if (hp[0]) begin
                        lead = 1'b1;
                    end else begin
                        trail = 1'b1;
                    end
                end
            end
            M_HOLD: begin
                if (half_end) begin
                    finish  = 1'b1;
                    state_n = M_GAP;
                end
            end
            M_GAP: begin
                if (half_end) state_n = M_IDLE;
            end
            default: state_n = M_IDLE;
        endcase
    end

    // launch_q resets high so a launch held through reset release is not an edge.
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            launch_q                <= 1'b1;
            cnt                     <= '0;
            hp                      <= '0;
            tx_sr                   <= '0;
            rx_sr                   <= '0;
            OUT_CS                  <= 1'b1;
            OUT_SCLK                <= IDLE_LVL;
            OUT_MOSI                <= 1'b0;
            OUT_MASTER_RECEIVE_DATA <= '0;
            OUT_MASTER_ACTION_DONE  <= 1'b0;
        end else begin
            launch_q               <= IN_LAUNCH;
            OUT_MASTER_ACTION_DONE <= 1'b0;

            if (state == M_IDLE || half_end) cnt <= '0;
            else                             cnt <= cnt + CNT_W'(1);

            if (state != M_SHIFT) hp <= '0;
            else if (half_end)    hp <= hp + HP_W'(1);

            if (start) begin
                tx_sr    <= IN_MASTER_DATA;
                OUT_MOSI <= head(IN_MASTER_DATA, M_TX_MSB);
                OUT_CS   <= 1'b0;
            end

            if (lead) begin
                OUT_SCLK <= ~IDLE_LVL;
                if (!CPHA1) begin
                    rx_sr <= insert(rx_sr, IN_MISO, M_RX_MSB);
                end else if (!first_lead) begin
                    tx_sr    <= tx_adv;
                    OUT_MOSI <= head(tx_adv, M_TX_MSB);
                end
            end

            if (trail) begin
                OUT_SCLK <= IDLE_LVL;
                if (CPHA1) begin
                    rx_sr <= insert(rx_sr, IN_MISO, M_RX_MSB);
                end else begin
                    tx_sr    <= tx_adv;
                    OUT_MOSI <= head(tx_adv, M_TX_MSB);
                end
            end

            if (finish) begin
                OUT_CS                  <= 1'b1;
                OUT_MOSI                <= 1'b0;
                OUT_MASTER_ACTION_DONE  <= 1'b1;
                OUT_MASTER_RECEIVE_DATA <= rx_sr;
            end
        end
    end

    logic                   s_sclk_q, s_cs_q;
    logic                   s_cs_fall, s_cs_rise, s_lead, s_trail;
    logic                   s_sample, s_shift;
    logic [PACK_LENGTH-1:0] s_tx, s_rx, s_tx_adv;
    logic [BC_W-1:0]        s_cnt;

    assign s_cs_fall = s_cs_q && !IN_SLAVE_CS;
    assign s_cs_rise = !s_cs_q && IN_SLAVE_CS;
    assign s_lead    = (s_sclk_q == IDLE_LVL) && (IN_SLAVE_SCLK != IDLE_LVL);
    assign s_trail   = (s_sclk_q != IDLE_LVL) && (IN_SLAVE_SCLK == IDLE_LVL);
    assign s_sample  = CPHA1 ? s_trail : s_lead;
    // With CPHA=1 no bit has been sampled yet at the first leading edge, so bit 0 stays.
    assign s_shift   = CPHA1 ? (s_lead && (s_cnt != '0)) : s_trail;
    assign s_tx_adv  = advance(s_tx, S_TX_MSB);

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            s_sclk_q               <= IDLE_LVL;
            s_cs_q                 <= 1'b1;
            s_tx                   <= '0;
            s_rx                   <= '0;
            s_cnt                  <= '0;
            OUT_SLAVE_MISO         <= 1'b0;
            OUT_SLAVE_RECEIVE_DATA <= '0;
        end else begin
            s_sclk_q <= IN_SLAVE_SCLK;
            s_cs_q   <= IN_SLAVE_CS;
            if (IN_SLAVE_RESET) begin
                s_tx                   <= '0;
                s_rx                   <= '0;
                s_cnt                  <= '0;
                OUT_SLAVE_MISO         <= 1'b0;
                OUT_SLAVE_RECEIVE_DATA <= '0;
            end else if (s_cs_fall) begin
                s_tx           <= IN_SLAVE_TRANSMIT_DATA;
                s_cnt          <= '0;
                OUT_SLAVE_MISO <= head(IN_SLAVE_TRANSMIT_DATA, S_TX_MSB);
            end else if (s_cs_rise) begin
                if (s_cnt == BC_W'(PACK_LENGTH)) OUT_SLAVE_RECEIVE_DATA <= s_rx;
                s_cnt          <= '0;
                OUT_SLAVE_MISO <= 1'b0;
            end else if (IN_SLAVE_CS) begin
                OUT_SLAVE_MISO <= 1'b0;
            end else begin
                if (s_sample) begin
                    s_rx <= insert(s_rx, IN_SLAVE_MOSI, S_RX_MSB);
                    if (s_cnt != '1) s_cnt <= s_cnt + BC_W'(1);
                end
                if (s_shift) begin
                    s_tx           <= s_tx_adv;
                    OUT_SLAVE_MISO <= head(s_tx_adv, S_TX_MSB);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_fpga_master_slave.sv
// Directed bench: four master/slave loopback instances covering the default mode,
// CPHA=0, CPHA=0 with CPOL=1, and inverted bit orders; instance 0's slave can be driven by hand.
module tb_spi_fpga_master_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, launch, slave_rst;
    logic [7:0] mdata, sdata;
    logic       man, man_cs, man_sclk, man_mosi;

    wire [3:0]      mosi, cs, sclk, done, smiso;
    wire [3:0]      s_cs, s_sclk, s_mosi;
    wire [3:0][7:0] mrx, srx;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign s_cs[g]   = (g == 0 && man) ? man_cs   : cs[g];
        assign s_sclk[g] = (g == 0 && man) ? man_sclk : sclk[g];
        assign s_mosi[g] = (g == 0 && man) ? man_mosi : mosi[g];

        spi_fpga_master_slave #(
            .CPOL                              ((g == 2) ? 1 : 0),
            .CPHA                              ((g == 1 || g == 2) ? 0 : 1),
            .MASTER_PACK_BIT_SEQUENCE_TRANSMIT ((g == 3) ? 0 : 1),
            .MASTER_PACK_BIT_SEQUENCE_RECEIVE  ((g == 3) ? 1 : 0),
            .SLAVE_PACK_BIT_SEQUENCE_TRANSMIT  ((g == 3) ? 1 : 0),
            .SLAVE_PACK_BIT_SEQUENCE_RECEIVE   ((g == 3) ? 0 : 1)
        ) dut (
            .IN_CLOCK                (clk),
            .IN_RESET_N              (rst_n),
            .IN_LAUNCH               (launch),
            .IN_MASTER_DATA          (mdata),
            .IN_MISO                 (smiso[g]),
            .OUT_MOSI                (mosi[g]),
            .OUT_CS                  (cs[g]),
            .OUT_SCLK                (sclk[g]),
            .OUT_MASTER_RECEIVE_DATA (mrx[g]),
            .OUT_MASTER_ACTION_DONE  (done[g]),
            .IN_SLAVE_TRANSMIT_DATA  (sdata),
            .IN_SLAVE_MOSI           (s_mosi[g]),
            .IN_SLAVE_CS             (s_cs[g]),
            .IN_SLAVE_SCLK           (s_sclk[g]),
            .IN_SLAVE_RESET          (slave_rst),
            .OUT_SLAVE_MISO          (smiso[g]),
            .OUT_SLAVE_RECEIVE_DATA  (srx[g])
        );
    end

    int cs_low = 0;
    int done_cnt [4] = '{0, 0, 0, 0};
    always @(posedge clk) begin
        if (!cs[0]) cs_low++;
        for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
    end

    // Serial lines captured at each instance's sampling edge, first bit ends in the MSB.
    logic [7:0] mosi_cap0, miso_cap0, mosi_cap3, miso_cap1, miso_cap2;
    always @(negedge sclk[0]) begin
        mosi_cap0 <= {mosi_cap0[6:0], mosi[0]};
        miso_cap0 <= {miso_cap0[6:0], smiso[0]};
    end
    always @(negedge sclk[3]) mosi_cap3 <= {mosi_cap3[6:0], mosi[3]};
    always @(posedge sclk[1]) miso_cap1 <= {miso_cap1[6:0], smiso[1]};
    always @(negedge sclk[2]) miso_cap2 <= {miso_cap2[6:0], smiso[2]};

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int         cs_snap;
    int         d_snap [4];
    logic [7:0] pat, cap;

    initial begin
        rst_n = 1'b1; launch = 1'b1; slave_rst = 1'b0;
        mdata = 8'hEA; sdata = 8'h53;
        man = 1'b0; man_cs = 1'b1; man_sclk = 1'b0; man_mosi = 1'b0;
        #2 rst_n = 1'b0;
        tick(3);
        check("rst_cs", cs[0], 1);
        check("rst_sclk_cpol0", sclk[0], 0);
        check("rst_sclk_cpol1", sclk[2], 1);
        check("rst_mosi", mosi[0], 0);
        check("rst_done", done[0], 0);
        check("rst_mrx", mrx[0], 8'h00);
        check("rst_srx", srx[0], 8'h00);
        check("rst_smiso", smiso[0], 0);

        cs_snap = cs_low; d_snap = done_cnt;
        rst_n = 1'b1;
        tick(10);
        check("held_launch_cs_low_clocks", cs_low - cs_snap, 0);
        check("held_launch_done", done_cnt[0] - d_snap[0], 0);

        launch = 1'b0; slave_rst = 1'b1;
        tick(3);
        slave_rst = 1'b0;
        tick(2);

        cs_snap = cs_low; d_snap = done_cnt;
        launch = 1'b1;
        tick(100);
        launch = 1'b0;
        tick(5);
        check("cs_low_clocks", cs_low - cs_snap, 36);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("done_pulses_%0d", i), done_cnt[i] - d_snap[i], 1);
            check($sformatf("master_rx_%0d", i), mrx[i], 8'h53);
            check($sformatf("slave_rx_%0d", i), srx[i], 8'hEA);
        end
        check("mosi_seq_default", mosi_cap0, 8'hEA);
        check("miso_seq_default", miso_cap0, 8'hCA);
        check("mosi_seq_reversed", mosi_cap3, 8'h57);
        check("miso_seq_cpha0", miso_cap1, 8'hCA);
        check("miso_seq_cpha0_cpol1", miso_cap2, 8'hCA);
        check("idle_sclk_cpol1", sclk[2], 1);
        check("idle_sclk_cpol0", sclk[1], 0);
        check("idle_cs", cs[0], 1);

        d_snap = done_cnt;
        mdata = 8'h3C; sdata = 8'hA5;
        launch = 1'b1;
        tick(1);
        mdata = 8'hFF;
        tick(12);
        #2 rst_n = 1'b0;
        #1 check("abort_cs_immediate", cs[0], 1);
        check("abort_sclk", sclk[0], 0);
        tick(2);
        check("abort_no_done", done_cnt[0] - d_snap[0], 0);
        check("abort_mrx", mrx[0], 8'h00);
        check("abort_srx", srx[0], 8'h00);
        rst_n = 1'b1; launch = 1'b0;
        tick(3);

        cs_snap = cs_low; d_snap = done_cnt;
        mdata = 8'h3C;
        launch = 1'b1;
        tick(1);
        mdata = 8'hFF;
        launch = 1'b0;
        tick(3);
        launch = 1'b1;
        tick(50);
        launch = 1'b0;
        check("relaunch_done", done_cnt[0] - d_snap[0], 1);
        check("relaunch_cs_low_clocks", cs_low - cs_snap, 36);
        check("relaunch_master_rx", mrx[0], 8'hA5);
        check("relaunch_slave_rx", srx[0], 8'h3C);
        check("relaunch_master_rx_rev", mrx[3], 8'hA5);
        check("relaunch_slave_rx_rev", srx[3], 8'h3C);

        man = 1'b1; man_cs = 1'b1; sdata = 8'h4B;
        tick(2);
        man_cs = 1'b0;
        tick(2);
        check("slave_first_bit", smiso[0], 1);
        for (int i = 0; i < 5; i++) begin
            man_mosi = 1'b1; man_sclk = 1'b1;
            tick(2);
            man_sclk = 1'b0;
            tick(2);
        end
        man_cs = 1'b1;
        tick(3);
        check("partial_frame_unchanged", srx[0], 8'h3C);
        check("cs_high_miso", smiso[0], 0);

        pat = 8'h96; cap = 8'h00;
        man_cs = 1'b0;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            man_mosi = pat[7 - i]; man_sclk = 1'b1;
            tick(2);
            cap = {cap[6:0], smiso[0]};
            man_sclk = 1'b0;
            tick(2);
        end
        man_cs = 1'b1;
        tick(3);
        check("manual_slave_rx", srx[0], 8'h96);
        check("manual_miso_seq", cap, 8'hD2);

        slave_rst = 1'b1;
        tick(1);
        slave_rst = 1'b0;
        check("slave_reset_rx", srx[0], 8'h00);
        check("slave_reset_rx_loop", srx[1], 8'h00);
        check("slave_reset_keeps_master", mrx[1], 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_fpga_master_slave.md
SPI_FPGA_MASTER_SLAVE -- requirements
Module: spi_fpga_master_slave

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- BIT_PER_SECOND, 12500000, SCLK bit rate.
- CLOCK_FREQUENCY, 50000000, IN_CLOCK frequency.
- PACK_LENGTH, 8, bits per packet.
- CPOL, 0, SCLK idle level.
- CPHA, 1, 0 = sample on leading edge; 1 = shift on leading edge and sample on trailing edge.
- MASTER_PACK_BIT_SEQUENCE_TRANSMIT, 1, 1 = MSB first; 0 = LSB first.
- MASTER_PACK_BIT_SEQUENCE_RECEIVE, 0, same encoding.
- SLAVE_PACK_BIT_SEQUENCE_TRANSMIT, 0, same encoding.
- SLAVE_PACK_BIT_SEQUENCE_RECEIVE, 1, same encoding.

REQ-002 Derived constant: HALF = CLOCK_FREQUENCY/(2*BIT_PER_SECOND), which is 2 clocks at the defaults; HALF shall be >= 2.

REQ-003 Ports, one per line (name, direction, width, meaning):
- IN_CLOCK, in, 1, single clock for all logic.
- IN_RESET_N, in, 1, asynchronous active-low reset.
- IN_LAUNCH, in, 1, master transfer request.
- IN_MASTER_DATA, in, PACK_LENGTH, master transmit word.
- IN_MISO, in, 1, master serial input.
- OUT_MOSI, out, 1, master serial output.
- OUT_CS, out, 1, master chip select, active low.
- OUT_SCLK, out, 1, master serial clock.
- OUT_MASTER_RECEIVE_DATA, out, PACK_LENGTH, last word received by the master.
- OUT_MASTER_ACTION_DONE, out, 1, one-clock completion pulse.
- IN_SLAVE_TRANSMIT_DATA, in, PACK_LENGTH, slave transmit word.
- IN_SLAVE_MOSI, in, 1, slave serial input.
- IN_SLAVE_CS, in, 1, slave chip select, active low.
- IN_SLAVE_SCLK, in, 1, slave serial clock.
- IN_SLAVE_RESET, in, 1, synchronous active-high clear of the slave section.
- OUT_SLAVE_MISO, out, 1, slave serial output.
- OUT_SLAVE_RECEIVE_DATA, out, PACK_LENGTH, last word received by the slave.

REQ-004 One clock domain (IN_CLOCK), all flops reset asynchronously by IN_RESET_N low; slave SPI inputs are sampled by IN_CLOCK (no SCLK-clocked flops).

Function -- master
REQ-005 States: IDLE, SETUP, SHIFT, HOLD, GAP.

REQ-006 IDLE: OUT_CS=1, OUT_SCLK=CPOL, OUT_MOSI=0. A rising edge of IN_LAUNCH (sampled high, previous sample low) latches IN_MASTER_DATA and moves to SETUP; a held-high IN_LAUNCH does not retrigger.

REQ-007 SETUP (HALF clocks): OUT_CS=0, OUT_MOSI = first transmit bit.

REQ-008 SHIFT (2*PACK_LENGTH half-periods): OUT_SCLK toggles every HALF clocks, starting with the leading edge.

REQ-009 Data edges: sample IN_MISO on the leading edge if CPHA=0, otherwise on the trailing edge. Change OUT_MOSI on the trailing edge if CPHA=0, otherwise on the leading edge; with CPHA=1 the first leading edge re-presents bit 0.

REQ-010 Transmit order: MSB first when MASTER_PACK_BIT_SEQUENCE_TRANSMIT=1, else LSB first. Receive order: the first received bit lands in the MSB when MASTER_PACK_BIT_SEQUENCE_RECEIVE=1, else in bit 0.

REQ-011 HOLD (HALF clocks): OUT_SCLK=CPOL, OUT_CS=0.

REQ-012 End of HOLD: OUT_CS=1, OUT_MASTER_RECEIVE_DATA updated with the full word, OUT_MASTER_ACTION_DONE=1 for exactly that one clock. Then GAP for HALF clocks, then IDLE.

REQ-013 OUT_CS is low for exactly (2*PACK_LENGTH+2)*HALF clocks, which is 36 at the defaults.

REQ-014 IN_LAUNCH changes during SETUP, SHIFT, HOLD or GAP are ignored; IN_MASTER_DATA is used only at latch time.

Function -- slave
REQ-015 Register IN_SLAVE_SCLK and IN_SLAVE_CS once. Edges are detected by comparing the live input with its registered copy; leading/trailing edges are defined relative to CPOL.

REQ-016 IN_SLAVE_CS falling: load IN_SLAVE_TRANSMIT_DATA into the shift register; on the next clock OUT_SLAVE_MISO = first bit.

REQ-017 While IN_SLAVE_CS=0:
- Sample IN_SLAVE_MOSI on the detected sampling edge, same CPHA rule as the master.
- Advance OUT_SLAVE_MISO on the detected shifting edge; with CPHA=1 the first leading edge keeps bit 0.
- OUT_SLAVE_MISO is updated within 1 clock of the edge.

REQ-018 Slave bit order follows SLAVE_PACK_BIT_SEQUENCE_TRANSMIT and SLAVE_PACK_BIT_SEQUENCE_RECEIVE, with the encoding of REQ-010.

REQ-019 IN_SLAVE_CS rising: OUT_SLAVE_RECEIVE_DATA is updated with the received word only if exactly PACK_LENGTH bits were sampled; otherwise it is unchanged. The bit counter then clears.

REQ-020 IN_SLAVE_CS high: OUT_SLAVE_MISO=0.

REQ-021 IN_SLAVE_RESET=1 synchronously clears the slave shift registers, bit counter, OUT_SLAVE_MISO and OUT_SLAVE_RECEIVE_DATA, with priority over all slave activity.

Reset
REQ-022 Outputs while IN_RESET_N=0:
- OUT_CS=1, OUT_SCLK=CPOL, OUT_MOSI=0.
- OUT_MASTER_RECEIVE_DATA=0, OUT_MASTER_ACTION_DONE=0.
- OUT_SLAVE_MISO=0, OUT_SLAVE_RECEIVE_DATA=0.
- Master in IDLE; launch edge detector cleared, so a launch held high through reset release does not start a transfer.

REQ-023 Reset asserted mid-transfer aborts the transfer immediately: no done pulse, receive registers unchanged from their reset value.

Verification
REQ-024 Master connected to slave, defaults:
- Stimulus: IN_SLAVE_RESET pulse for 3 clocks; IN_MASTER_DATA=0xEA; IN_SLAVE_TRANSMIT_DATA=0x53; IN_LAUNCH rises.
- MOSI sequence: 1,1,1,0,1,0,1,0.
- MISO sequence: 1,1,0,0,1,0,1,0.
- Results: OUT_SLAVE_RECEIVE_DATA=0xEA, OUT_MASTER_RECEIVE_DATA=0x53, one done pulse, OUT_CS low for 36 clocks.

REQ-025 IN_LAUNCH held high for 100 clocks -> exactly one transfer and one done pulse.

REQ-026 Same data with CPHA=0 and then CPOL=1 -> identical received words; SCLK idles at CPOL; the first MISO bit is valid before the first sampling edge.

REQ-027 All four bit-order parameters inverted -> MOSI sequence 0,1,0,1,0,1,1,1; both words are still received correctly.

REQ-028 IN_SLAVE_CS released after 5 SCLK cycles -> OUT_SLAVE_RECEIVE_DATA unchanged.

REQ-029 IN_RESET_N pulsed low mid-SHIFT -> OUT_CS=1 at once, no done pulse, and the next launch completes normally.
